// File: rtl/ex_mem_stage.sv
// ----------------------------------------------------------------------------
// ex_mem_stage
//   EX/MEM pipeline register of the 32-bit five-stage MIPS pipeline. Captures
//   the ALU result, zero flag, store data, destination register, branch target
//   and the memory/writeback control bits. It also resolves the branch decision
//   from registered state, flags when this stage is a valid forwarding source,
//   and keeps retire / taken-branch performance counters.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   stall, flush        hold contents / load a bubble (flush wins)
//   ex_*                EX-stage values to be captured
//   mem_*               registered copies of the ex_* values
//   mem_pc_src          branch taken (valid & branch & zero), from registers
//   mem_fwd_en          stage is a forwarding source (never for $0)
//   instr_count         valid instructions loaded, wraps at 2^CNT_W
//   branch_count        taken branches, counted once even if held by stall
// ----------------------------------------------------------------------------
module ex_mem_stage #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned REG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             ex_valid,
  input  logic [31:0]      ex_alu_result,
  input  logic             ex_zero,
  input  logic [31:0]      ex_write_data,
  input  logic [REG_W-1:0] ex_write_reg,
  input  logic [31:0]      ex_branch_target,
  input  logic             ex_reg_write,
  input  logic             ex_mem_to_reg,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic             ex_branch,
  output logic             mem_valid,
  output logic [31:0]      mem_alu_result,
  output logic             mem_zero,
  output logic [31:0]      mem_write_data,
  output logic [REG_W-1:0] mem_write_reg,
  output logic [31:0]      mem_branch_target,
  output logic             mem_reg_write,
  output logic             mem_mem_to_reg,
  output logic             mem_mem_read,
  output logic             mem_mem_write,
  output logic             mem_pc_src,
  output logic             mem_fwd_en,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] branch_count
);

  // Branch control bit is internal only; it feeds mem_pc_src.
  logic mem_branch;

  // A load edge: neither held nor replaced by a bubble.
  logic load_en;
  assign load_en = !flush && !stall;

  // Pipeline register. Control bits are gated with ex_valid so that a bubble
  // entering from EX can never write the register file or memory.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_valid         <= 1'b0;
      mem_alu_result    <= '0;
      mem_zero          <= 1'b0;
      mem_write_data    <= '0;
      mem_write_reg     <= '0;
      mem_branch_target <= '0;
      mem_reg_write     <= 1'b0;
      mem_mem_to_reg    <= 1'b0;
      mem_mem_read      <= 1'b0;
      mem_mem_write     <= 1'b0;
      mem_branch        <= 1'b0;
    end else if (flush) begin
      mem_valid         <= 1'b0;
      mem_alu_result    <= '0;
      mem_zero          <= 1'b0;
      mem_write_data    <= '0;
      mem_write_reg     <= '0;
      mem_branch_target <= '0;
      mem_reg_write     <= 1'b0;
      mem_mem_to_reg    <= 1'b0;
      mem_mem_read      <= 1'b0;
      mem_mem_write     <= 1'b0;
      mem_branch        <= 1'b0;
    end else if (!stall) begin
      mem_valid         <= ex_valid;
      mem_alu_result    <= ex_alu_result;
      mem_zero          <= ex_zero;
      mem_write_data    <= ex_write_data;
      mem_write_reg     <= ex_write_reg;
      mem_branch_target <= ex_branch_target;
      mem_reg_write     <= ex_reg_write  & ex_valid;
      mem_mem_to_reg    <= ex_mem_to_reg & ex_valid;
      mem_mem_read      <= ex_mem_read   & ex_valid;
      mem_mem_write     <= ex_mem_write  & ex_valid;
      mem_branch        <= ex_branch     & ex_valid;
    end
  end

  // Decisions derived purely from registered state: no ex_* to mem_* path.
  always_comb begin
    mem_pc_src = mem_valid & mem_branch & mem_zero;
    mem_fwd_en = mem_valid & mem_reg_write & (mem_write_reg != '0);
  end

  // Retire counter: one per valid instruction actually loaded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_count <= '0;
    end else if (load_en && ex_valid) begin
      instr_count <= instr_count + CNT_W'(1);
    end
  end

  // Taken-branch counter: a branch held by stall is counted on the edge that
  // releases it. The flush edge that follows a taken branch still counts it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      branch_count <= '0;
    end else if (mem_pc_src && !stall) begin
      branch_count <= branch_count + CNT_W'(1);
    end
  end

endmodule
